biriscv_issue_scoreboard: RTL and testbench

BIRISCV_ISSUE_SCOREBOARD -- requirements
Module: biriscv_issue_scoreboard

---
 rtl/biriscv_issue_scoreboard.sv | 171 +++++++++++++++++
 tb/tb_biriscv_issue_scoreboard.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_issue_scoreboard.sv
// Issue-stage register scoreboard for a dual-pipe RISC-V core.
//
// Tracks destination registers of long-latency instructions (loads, multiplies and
// divides) and stalls issue of any instruction that reads or overwrites one of them
// before its result is available. Also sequences the out-of-pipe divider.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   issue_*_i                instruction presented at issue (class flags, ra/rb/rd)
//   pipe_stall_i             pipeline stall; blocks new pending bits only
//   squash_i                 flush of E1/E2; drops all pending state and aborts a divide
//   e2_valid_i / e2_rd_i     result available at E2 (bypassable)
//   wb_valid_i / wb_rd_i     result committed at writeback
//   div_complete_i           divider result returned
//   stall_o                  issue hazard (combinational)
//   div_start_o/div_abort_o  divider launch / cancel pulses
//   div_busy_o               divider in flight
//   div_cycles_o             busy-cycle count of current or last divide (saturating)
//   pending_o                union of all outstanding destination registers
module biriscv_issue_scoreboard #(
  parameter int unsigned SUPPORT_LOAD_BYPASS = 1,
  parameter int unsigned SUPPORT_MUL_BYPASS  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic        issue_lsu_i,
  input  logic        issue_mul_i,
  input  logic        issue_div_i,
  input  logic        issue_rd_valid_i,
  input  logic [4:0]  issue_ra_i,
  input  logic [4:0]  issue_rb_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        pipe_stall_i,
  input  logic        squash_i,
  input  logic        e2_valid_i,
  input  logic [4:0]  e2_rd_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        div_complete_i,
  output logic        stall_o,
  output logic        div_start_o,
  output logic        div_abort_o,
  output logic        div_busy_o,
  output logic [15:0] div_cycles_o,
  output logic [31:0] pending_o
);

  typedef enum logic {StIdle, StBusy} div_state_e;

  div_state_e  state_q, state_d;
  logic [31:0] pend_e2_q, pend_e2_d;
  logic [31:0] pend_wb_q, pend_wb_d;
  logic [4:0]  div_rd_q, div_rd_d;
  logic        div_pend_q, div_pend_d;
  logic [15:0] div_cycles_q, div_cycles_d;

  logic [31:0] div_vec;
  logic [31:0] pend_all;
  logic [31:0] set_e2, set_wb, clr_e2, clr_wb;
  logic        fire;
  logic        div_fire;

  // Hazard map is built from registered state only, so a clear in the current
  // cycle releases the stall one cycle later.
  always_comb begin
    div_vec = '0;
    if (div_pend_q) begin
      div_vec[div_rd_q] = 1'b1;
    end
    pend_all = (pend_e2_q | pend_wb_q | div_vec) & ~32'd1;
  end

  assign pending_o = pend_all;

  assign stall_o = issue_valid_i &
                   (pend_all[issue_ra_i] | pend_all[issue_rb_i] |
                    (issue_rd_valid_i & pend_all[issue_rd_i]) |
                    (issue_div_i & div_busy_o));

  assign fire     = issue_valid_i & ~stall_o & ~pipe_stall_i & ~squash_i;
  assign div_fire = fire & issue_div_i;

  // Pending-bit set/clear masks; set wins over a clear of the same bit.
  always_comb begin
    set_e2 = '0;
    set_wb = '0;
    clr_e2 = '0;
    clr_wb = '0;
    if (fire && issue_rd_valid_i && (issue_rd_i != 5'd0)) begin
      if (issue_lsu_i) begin
        if (SUPPORT_LOAD_BYPASS != 0) set_e2[issue_rd_i] = 1'b1;
        else                          set_wb[issue_rd_i] = 1'b1;
      end else if (issue_mul_i) begin
        if (SUPPORT_MUL_BYPASS != 0) set_e2[issue_rd_i] = 1'b1;
        else                         set_wb[issue_rd_i] = 1'b1;
      end
    end
    if (e2_valid_i) clr_e2[e2_rd_i] = 1'b1;
    if (wb_valid_i) clr_wb[wb_rd_i] = 1'b1;
  end

  always_comb begin
    if (squash_i) begin
      pend_e2_d = '0;
      pend_wb_d = '0;
    end else begin
      pend_e2_d = ((pend_e2_q & ~clr_e2) | set_e2) & ~32'd1;
      pend_wb_d = ((pend_wb_q & ~clr_wb) | set_wb) & ~32'd1;
    end
  end

  // Divider destination tracking and busy-cycle counter.
  always_comb begin
    div_rd_d     = div_rd_q;
    div_pend_d   = div_pend_q;
    div_cycles_d = div_cycles_q;
    if (div_fire) begin
      div_rd_d   = issue_rd_valid_i ? issue_rd_i : 5'd0;
      div_pend_d = 1'b1;
    end else if (squash_i) begin
      div_pend_d = 1'b0;
    end else if (div_busy_o && div_complete_i) begin
      div_pend_d = 1'b0;
    end
    if (div_fire) begin
      div_cycles_d = 16'd0;
    end else if (div_busy_o && (div_cycles_q != 16'hffff)) begin
      div_cycles_d = div_cycles_q + 16'd1;
    end
  end

  // Divider FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (div_fire) state_d = StBusy;
      StBusy: if (div_complete_i || squash_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Divider FSM: outputs. Pulses are suppressed while reset is asserted.
  always_comb begin
    div_busy_o  = (state_q == StBusy);
    div_start_o = div_fire & ~rst_i;
    div_abort_o = squash_i & (state_q == StBusy) & ~div_complete_i & ~rst_i;
  end

  assign div_cycles_o = div_cycles_q;

  // Divider FSM state register and scoreboard state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pend_e2_q    <= '0;
      pend_wb_q    <= '0;
      div_rd_q     <= '0;
      div_pend_q   <= 1'b0;
      div_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_e2_q    <= pend_e2_d;
      pend_wb_q    <= pend_wb_d;
      div_rd_q     <= div_rd_d;
      div_pend_q   <= div_pend_d;
      div_cycles_q <= div_cycles_d;
    end
  end

endmodule

// File: tb/tb_biriscv_issue_scoreboard.sv
// Self-checking bench for biriscv_issue_scoreboard. Two instances share stimulus:
// index 0 has load/mul bypass enabled, index 1 has both disabled.
module tb_biriscv_issue_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, iv, lsu, mul, div, rdv, ps, sq, e2v, wbv, dc;
  logic [4:0] ra, rb, rd, e2rd, wbrd;

  logic [1:0]  stall, div_start, div_abort, div_busy;
  logic [15:0] div_cycles [2];
  logic [31:0] pending [2];

  int vectors = 0;
  int miscompares = 0;

  biriscv_issue_scoreboard #(
    .SUPPORT_LOAD_BYPASS(1),
    .SUPPORT_MUL_BYPASS (1)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .issue_lsu_i(lsu), .issue_mul_i(mul),
    .issue_div_i(div), .issue_rd_valid_i(rdv), .issue_ra_i(ra), .issue_rb_i(rb),
    .issue_rd_i(rd), .pipe_stall_i(ps), .squash_i(sq), .e2_valid_i(e2v), .e2_rd_i(e2rd),
    .wb_valid_i(wbv), .wb_rd_i(wbrd), .div_complete_i(dc), .stall_o(stall[0]),
    .div_start_o(div_start[0]), .div_abort_o(div_abort[0]), .div_busy_o(div_busy[0]),
    .div_cycles_o(div_cycles[0]), .pending_o(pending[0])
  );

  biriscv_issue_scoreboard #(
    .SUPPORT_LOAD_BYPASS(0),
    .SUPPORT_MUL_BYPASS (0)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .issue_lsu_i(lsu), .issue_mul_i(mul),
    .issue_div_i(div), .issue_rd_valid_i(rdv), .issue_ra_i(ra), .issue_rb_i(rb),
    .issue_rd_i(rd), .pipe_stall_i(ps), .squash_i(sq), .e2_valid_i(e2v), .e2_rd_i(e2rd),
    .wb_valid_i(wbv), .wb_rd_i(wbrd), .div_complete_i(dc), .stall_o(stall[1]),
    .div_start_o(div_start[1]), .div_abort_o(div_abort[1]), .div_busy_o(div_busy[1]),
    .div_cycles_o(div_cycles[1]), .pending_o(pending[1])
  );

  // Reference model: per-register "awaiting E2" / "awaiting WB" flags plus divider status.
  bit          m_e2 [2][32];
  bit          m_wb [2][32];
  bit          m_busy [2];
  bit          m_dpend [2];
  logic [4:0]  m_drd [2];
  int unsigned m_cyc [2];

  function automatic bit m_haz(int k, logic [4:0] x);
    if (x == 0) return 1'b0;
    return m_e2[k][x] || m_wb[k][x] || (m_dpend[k] && m_drd[k] == x);
  endfunction

  function automatic bit m_stall(int k);
    return iv && (m_haz(k, ra) || m_haz(k, rb) || (rdv && m_haz(k, rd)) || (div && m_busy[k]));
  endfunction

  function automatic bit m_fire(int k);
    return iv && !m_stall(k) && !ps && !sq;
  endfunction

  function automatic logic [31:0] m_pending(int k);
    logic [31:0] p = '0;
    for (int i = 1; i < 32; i++) p[i] = m_haz(k, 5'(i));
    return p;
  endfunction

  task automatic m_update();
    for (int k = 0; k < 2; k++) begin
      bit f = m_fire(k);
      bit was_busy = m_busy[k];
      if (rst) begin
        for (int i = 0; i < 32; i++) begin m_e2[k][i] = 0; m_wb[k][i] = 0; end
        m_busy[k] = 0; m_dpend[k] = 0; m_drd[k] = 0; m_cyc[k] = 0;
      end else begin
        if (was_busy) m_cyc[k] = (m_cyc[k] == 65535) ? 65535 : m_cyc[k] + 1;
        if (sq) begin
          for (int i = 0; i < 32; i++) begin m_e2[k][i] = 0; m_wb[k][i] = 0; end
          m_dpend[k] = 0; m_busy[k] = 0;
        end else begin
          if (e2v) m_e2[k][e2rd] = 0;
          if (wbv) m_wb[k][wbrd] = 0;
          if (was_busy && dc) begin m_busy[k] = 0; m_dpend[k] = 0; end
          if (f && rdv && rd != 0 && (lsu || mul)) begin
            if (k == 0) m_e2[k][rd] = 1;  // bypass enabled: result usable at E2
            else        m_wb[k][rd] = 1;
          end
          if (f && div) begin
            m_drd[k] = rdv ? rd : 5'd0; m_dpend[k] = 1; m_busy[k] = 1; m_cyc[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; iv = 0; lsu = 0; mul = 0; div = 0; rdv = 0; ps = 0; sq = 0;
    e2v = 0; wbv = 0; dc = 0; ra = 0; rb = 0; rd = 0; e2rd = 0; wbrd = 0;
  endtask

  // cls: 0 alu, 1 load, 2 mul, 3 div
  task automatic set_instr(int cls, logic [4:0] a, logic [4:0] b, logic [4:0] d, bit v);
    iv = 1; lsu = (cls == 1); mul = (cls == 2); div = (cls == 3);
    ra = a; rb = b; rd = d; rdv = v;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    cyc(); cyc();
    set_instr(3, 0, 0, 1, 1);
    #1;
    vectors++; if (div_start !== 2'b00) begin miscompares++;
      $display("FAIL rst_start: got %b want 00", div_start); end
    vectors++; if (pending[0] !== 32'h0 || pending[1] !== 32'h0) begin miscompares++;
      $display("FAIL rst_pending: got %h/%h want 0", pending[0], pending[1]); end
    vectors++; if (div_busy !== 2'b00 || div_cycles[0] !== 16'h0) begin miscompares++;
      $display("FAIL rst_div: got busy %b cycles %h want 00/0", div_busy, div_cycles[0]); end
    vectors++; if (stall !== 2'b00) begin miscompares++;
      $display("FAIL rst_stall: got %b want 00", stall); end
    idle();
  endtask

  task automatic test_load_bypass();
    set_instr(1, 0, 0, 5, 1);
    #1;
    vectors++; if (stall[0] !== 1'b0) begin miscompares++;
      $display("FAIL load_issue_stall: got %b want 0", stall[0]); end
    cyc();
    set_instr(0, 5, 0, 1, 1); e2v = 1; e2rd = 5;
    #1;
    vectors++; if (stall !== 2'b11) begin miscompares++;
      $display("FAIL raw_stall: got %b want 11", stall); end
    vectors++; if (pending[0] !== 32'h20 || pending[1] !== 32'h20) begin miscompares++;
      $display("FAIL load_pending: got %h/%h want 20", pending[0], pending[1]); end
    cyc();
    e2v = 0;
    #1;
    vectors++; if (stall !== 2'b10) begin miscompares++;
      $display("FAIL e2_release: got %b want 10", stall); end
    vectors++; if (pending[0] !== 32'h0) begin miscompares++;
      $display("FAIL e2_clear: got %h want 0", pending[0]); end
    cyc();
    idle(); wbv = 1; wbrd = 5;
    cyc(); idle();
    #1;
    vectors++; if (pending[1] !== 32'h0) begin miscompares++;
      $display("FAIL wb_clear: got %h want 0", pending[1]); end
  endtask

  task automatic test_mul_nobypass();
    set_instr(2, 0, 0, 7, 1);
    cyc(); idle();
    #1;
    vectors++; if (pending[0] !== 32'h80 || pending[1] !== 32'h80) begin miscompares++;
      $display("FAIL mul_pending: got %h/%h want 80", pending[0], pending[1]); end
    e2v = 1; e2rd = 7;
    cyc(); idle();
    #1;
    vectors++; if (pending[0] !== 32'h0 || pending[1] !== 32'h80) begin miscompares++;
      $display("FAIL mul_e2: got %h/%h want 0/80", pending[0], pending[1]); end
    wbv = 1; wbrd = 7;
    cyc(); idle();
    #1;
    vectors++; if (pending[1] !== 32'h0) begin miscompares++;
      $display("FAIL mul_wb: got %h want 0", pending[1]); end
  endtask

  task automatic test_div();
    int busy_cnt = 0;
    int stall_bad = 0;
    int starts = 0;
    set_instr(3, 0, 0, 3, 1);
    #1;
    vectors++; if (div_start !== 2'b11) begin miscompares++;
      $display("FAIL div_start: got %b want 11", div_start); end
    cyc();
    set_instr(3, 0, 0, 4, 1);
    #1;
    vectors++; if (pending[0] !== 32'h8) begin miscompares++;
      $display("FAIL div_pending: got %h want 8", pending[0]); end
    for (int i = 1; i <= 20; i++) begin
      dc = (i == 20);
      #1;
      if (div_busy === 2'b11) busy_cnt++;
      if (stall !== 2'b11) stall_bad++;
      starts += int'(div_start[0]);
      cyc();
    end
    dc = 0;
    #1;
    vectors++; if (busy_cnt != 20) begin miscompares++;
      $display("FAIL div_busy_len: got %0d want 20", busy_cnt); end
    vectors++; if (stall_bad != 0 || starts != 0) begin miscompares++;
      $display("FAIL div_second_stall: got %0d bad stalls %0d starts want 0/0", stall_bad, starts); end
    vectors++; if (div_cycles[0] !== 16'd20 || div_cycles[1] !== 16'd20) begin miscompares++;
      $display("FAIL div_cycles: got %0d/%0d want 20", div_cycles[0], div_cycles[1]); end
    vectors++; if (div_busy !== 2'b00 || stall !== 2'b00 || div_start !== 2'b11) begin
      miscompares++;
      $display("FAIL div_idle_relaunch: got busy %b stall %b start %b want 00/00/11",
               div_busy, stall, div_start); end
    cyc(); idle();
    #1;
    vectors++; if (div_busy !== 2'b11 || pending[0] !== 32'h10 || div_cycles[0] !== 16'd0) begin
      miscompares++;
      $display("FAIL div2_state: got busy %b pend %h cyc %0d want 11/10/0",
               div_busy, pending[0], div_cycles[0]); end
  endtask

  task automatic test_squash();
    sq = 1;
    #1;
    vectors++; if (div_abort !== 2'b11) begin miscompares++;
      $display("FAIL sq_abort: got %b want 11", div_abort); end
    cyc(); idle();
    #1;
    vectors++; if (div_abort !== 2'b00 || div_busy !== 2'b00 || pending[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL sq_after: got abort %b busy %b pend %h want 00/00/0",
               div_abort, div_busy, pending[0]); end
    set_instr(3, 0, 0, 6, 1);
    cyc(); idle(); cyc();
    sq = 1; dc = 1;
    #1;
    vectors++; if (div_abort !== 2'b00) begin miscompares++;
      $display("FAIL sq_complete_abort: got %b want 00", div_abort); end
    cyc(); idle();
    #1;
    vectors++; if (div_busy !== 2'b00 || pending[1] !== 32'h0) begin miscompares++;
      $display("FAIL sq_complete_after: got busy %b pend %h want 00/0", div_busy, pending[1]); end
  endtask

  task automatic test_set_wins();
    set_instr(1, 0, 0, 9, 1); wbv = 1; wbrd = 9;
    cyc(); idle();
    set_instr(1, 0, 0, 10, 1); e2v = 1; e2rd = 10;
    cyc(); idle();
    set_instr(1, 0, 0, 0, 1); e2v = 1; e2rd = 0;
    #1;
    vectors++; if (stall !== 2'b00) begin miscompares++;
      $display("FAIL rd0_stall: got %b want 00", stall); end
    cyc(); idle();
    set_instr(0, 0, 0, 0, 1);
    #1;
    vectors++; if (stall !== 2'b00) begin miscompares++;
      $display("FAIL ra0_stall: got %b want 00", stall); end
    vectors++; if (pending[0] !== 32'h600 || pending[1] !== 32'h600) begin miscompares++;
      $display("FAIL set_wins: got %h/%h want 600", pending[0], pending[1]); end
    idle(); sq = 1;
    cyc(); idle();
  endtask

  task automatic test_reset_mid_div();
    set_instr(1, 0, 0, 4, 1); cyc();
    set_instr(2, 0, 0, 12, 1); cyc();
    set_instr(3, 0, 0, 2, 1); cyc();
    idle(); cyc();
    #1;
    vectors++; if (pending[0] !== 32'h1014 || pending[1] !== 32'h1014) begin miscompares++;
      $display("FAIL pre_rst_pending: got %h/%h want 1014", pending[0], pending[1]); end
    rst = 1; sq = 1;
    #1;
    vectors++; if (div_abort !== 2'b00) begin miscompares++;
      $display("FAIL rst_abort: got %b want 00", div_abort); end
    cyc(); idle();
    #1;
    vectors++; if (pending[0] !== 32'h0 || pending[1] !== 32'h0 || div_busy !== 2'b00 ||
                   div_cycles[0] !== 16'h0 || div_cycles[1] !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_mid_div: got pend %h/%h busy %b cyc %0d/%0d want 0/0/00/0/0",
               pending[0], pending[1], div_busy, div_cycles[0], div_cycles[1]); end
  endtask

  task automatic test_random();
    idle(); rst = 1; cyc(); idle();
    for (int n = 0; n < 3000; n++) begin
      set_instr(int'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0);
      iv   = $urandom_range(0, 9) < 7;
      ps   = $urandom_range(0, 9) == 0;
      sq   = $urandom_range(0, 29) == 0;
      e2v  = $urandom_range(0, 1) == 1;
      e2rd = 5'($urandom_range(0, 7));
      wbv  = $urandom_range(0, 1) == 1;
      wbrd = 5'($urandom_range(0, 7));
      dc   = $urandom_range(0, 7) == 0;
      rst  = $urandom_range(0, 199) == 0;
      #1;
      for (int k = 0; k < 2; k++) begin
        bit f = m_fire(k);
        vectors++; if (stall[k] !== m_stall(k)) begin miscompares++;
          $display("FAIL rnd_stall[%0d] n=%0d: got %b want %b", k, n, stall[k], m_stall(k)); end
        vectors++; if (div_start[k] !== (f && div && !rst)) begin miscompares++;
          $display("FAIL rnd_start[%0d] n=%0d: got %b want %b", k, n, div_start[k],
                   f && div && !rst); end
        vectors++; if (div_abort[k] !== (sq && m_busy[k] && !dc && !rst)) begin miscompares++;
          $display("FAIL rnd_abort[%0d] n=%0d: got %b want %b", k, n, div_abort[k],
                   sq && m_busy[k] && !dc && !rst); end
        vectors++; if (div_busy[k] !== m_busy[k]) begin miscompares++;
          $display("FAIL rnd_busy[%0d] n=%0d: got %b want %b", k, n, div_busy[k], m_busy[k]); end
        vectors++; if (div_cycles[k] !== 16'(m_cyc[k])) begin miscompares++;
          $display("FAIL rnd_cycles[%0d] n=%0d: got %0d want %0d", k, n, div_cycles[k],
                   m_cyc[k]); end
        vectors++; if (pending[k] !== m_pending(k)) begin miscompares++;
          $display("FAIL rnd_pending[%0d] n=%0d: got %h want %h", k, n, pending[k],
                   m_pending(k)); end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_bypass();
    test_mul_nobypass();
    test_div();
    test_squash();
    test_set_wins();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
